div_sub: RTL and testbench
==========================

Name: div_sub

Overview:
- Sequential unsigned divider using repeated subtraction; the inverse of the team's repeated-addition multiplier datapath.
- It latches a dividend and divisor on a start pulse.
- Each cycle it subtracts the divisor from a running remainder and increments a quotient counter, until the remainder is below the divisor.
- Sits beside the multiplier on the same 16-bit operand buses, with its own start/done handshake and an integrated controller FSM.

Parameters:
- WIDTH, 16, operand/result width in bits (dividend, divisor, quotient, remainder).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low; sampled on rising clk edge
- start  input  1  request a division; accepted only in IDLE
- dataa  input  WIDTH  dividend, sampled on the accepting edge
- datab  input  WIDTH  divisor, sampled on the accepting edge
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse: results valid
- div_zero  output  1  divisor was zero; held with results
- quot  output  WIDTH  quotient, held until next accepted start
- rem  output  WIDTH  remainder, held until next accepted start

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE; busy=0, done=0, div_zero=0, quot=0, rem=0; internal R, B, Q = 0. Reset wins over every other event, including mid-RUN; an in-flight division is discarded.
- States: IDLE, RUN, DONE; registered outputs only.
- IDLE:
  - start=1 at an edge: R<=dataa, B<=datab, Q<=0, div_zero<=0, state<=RUN.
  - quot/rem keep their previous values until DONE overwrites them.
  - start=0: stay in IDLE.
- RUN, evaluated each edge:
  - B==0: div_zero<=1, quot<=all-ones, rem<=R, done<=1, state<=DONE.
  - else R>=B (unsigned): R<=R-B, Q<=Q+1, stay in RUN.
  - else (R<B): quot<=Q, rem<=R, done<=1, state<=DONE.
- DONE: done<=0, state<=IDLE. done is therefore high for exactly one cycle.
- Latency: with start accepted at edge e0 and final quotient N, done is high in the cycle after edge e(N+1). N=0 or divisor zero gives 1 cycle; worst case (divisor=1, dividend=2^WIDTH-1) gives 2^WIDTH cycles.
- start is ignored in RUN and DONE, with no queueing. A start held high through DONE is accepted on the first IDLE edge after it.
- dataa/datab changes after acceptance have no effect.
- Arithmetic:
  - Compare and subtract are unsigned WIDTH bits; R-B never underflows because it is taken only when R>=B.
  - Q cannot overflow: N <= dividend <= 2^WIDTH-1.
- Invariant on normal completion: quot*datab + rem == dataa and rem < datab.

Decomposition:
- Shared package holds:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - default WIDTH=16 constant, shared with the multiplier datapath
- One natural sub-module, sub_cmp: combinational WIDTH-bit unit taking R and B, producing ge (R>=B), diff (R-B) and bz (B==0).
- The FSM, R/B/Q registers and output registers stay in div_sub.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> quot=0, rem=0, busy=0, done=0, div_zero=0. Release with start=0 -> all unchanged for 10 cycles.
- Basic divide: dataa=100, datab=7, start for 1 cycle -> busy high; done pulses exactly 15 cycles after the accepting edge; quot=14, rem=2, div_zero=0; values held after done drops.
- Boundaries:
  - dataa=5, datab=9 -> done after 1 cycle, quot=0, rem=5.
  - dataa=9, datab=9 -> quot=1, rem=0, done after 2 cycles.
  - dataa=65535, datab=1 -> quot=65535, rem=0, done after 65536 cycles.
- Divide by zero: dataa=1234, datab=0 -> done after 1 cycle, div_zero=1, quot=16'hFFFF, rem=1234. A following valid start (40/8) clears div_zero, giving quot=5, rem=0.
- Start while busy: start 200/3; pulse start with 50/5 during RUN -> ignored, result quot=66, rem=2. Start held continuously -> back-to-back divisions with busy dropping for exactly one IDLE cycle between them.
- Reset mid-operation: start 1000/1, assert rst_n=0 at cycle 20 -> next cycle busy=0, done=0, quot=0, rem=0. No done pulse follows; a fresh 81/9 gives quot=9, rem=0.

Source files
------------

// File: rtl/div_sub_pkg.sv
// Shared definitions for the repeated-subtraction divider: default operand
// width (common with the multiplier datapath) and controller state encoding.
package div_sub_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } div_state_t;

endpackage : div_sub_pkg

// File: rtl/div_sub_sub_cmp.sv
// Combinational compare/subtract step for the divider: reports R>=B, the
// difference R-B and whether the divisor is zero.
module sub_cmp
  import div_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] b,
  output logic             ge,
  output logic [WIDTH-1:0] diff,
  output logic             bz
);

  // diff is only consumed when ge is set, so the wrap below zero never matters.
  assign ge   = (r >= b);
  assign diff = r - b;
  assign bz   = (b == '0);

endmodule : sub_cmp

// File: rtl/div_sub.sv
// Sequential unsigned divider by repeated subtraction with an integrated
// IDLE/RUN/DONE controller and a start/done handshake.
module div_sub
  import div_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  // Handshake: start is sampled only while idle (busy low) and is never queued;
  // dataa/datab are captured on that same edge. done is a one-cycle pulse and
  // quot/rem/div_zero stay valid from done until the next accepted start.

  div_state_t       state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] q_q;

  logic             ge;
  logic             bz;
  logic [WIDTH-1:0] diff;

  sub_cmp #(.WIDTH(WIDTH)) u_sub_cmp (
    .r    (r_q),
    .b    (b_q),
    .ge   (ge),
    .diff (diff),
    .bz   (bz)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      r_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      quot     <= '0;
      rem      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_q      <= dataa;
            b_q      <= datab;
            q_q      <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Zero divisor is resolved before the compare, which would otherwise loop forever.
          if (bz) begin
            div_zero <= 1'b1;
            quot     <= '1;
            rem      <= r_q;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else if (ge) begin
            r_q <= diff;
            q_q <= q_q + WIDTH'(1);
          end else begin
            quot  <= q_q;
            rem   <= r_q;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : div_sub

// File: tb/tb_div_sub.sv
// Directed bench for div_sub: a vector table of divisions plus hand-written
// sequences for reset, start-while-busy, held start and mid-run reset.
module tb_div_sub;

  localparam int W     = 16;
  localparam int LIMIT = 70000;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dataa;
  logic [W-1:0] datab;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] quot;
  logic [W-1:0] rem;

  int n_vec;
  int n_err;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dz;
    int           exp_lat;
  } vec_t;

  vec_t vecs[9];

  div_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dataa    (dataa),
    .datab    (datab),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .quot     (quot),
    .rem      (rem)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one division and wait for done; inject>0 pulses a competing start
  // with other operands at that cycle of the run.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int inject,
                         output int lat);
    @(negedge clk);
    dataa = a;
    datab = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < LIMIT) begin
      @(negedge clk);
      lat++;
      start = (inject != 0 && lat == inject);
      if (start) begin
        dataa = 16'd50;
        datab = 16'd5;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat);
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " quot"}, quot, v.exp_q);
    chk({tag, " rem"}, rem, v.exp_r);
    chk({tag, " div_zero"}, div_zero, v.exp_dz);
    @(negedge clk);
    chk({tag, " done pulse width"}, done, 1'b0);
    chk({tag, " busy after done"}, busy, 1'b0);
    chk({tag, " quot held"}, quot, v.exp_q);
    chk({tag, " rem held"}, rem, v.exp_r);
  endtask

  initial begin
    int   lat;
    int   idle_cycles;
    int   seen_done;
    vec_t v;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    dataa = '0;
    datab = '0;

    vecs[0] = '{16'd100,   16'd7, 16'd14,    16'd2,    1'b0, 15};
    vecs[1] = '{16'd5,     16'd9, 16'd0,     16'd5,    1'b0, 1};
    vecs[2] = '{16'd9,     16'd9, 16'd1,     16'd0,    1'b0, 2};
    vecs[3] = '{16'd1234,  16'd0, 16'hFFFF,  16'd1234, 1'b1, 1};
    vecs[4] = '{16'd40,    16'd8, 16'd5,     16'd0,    1'b0, 6};
    vecs[5] = '{16'd0,     16'd5, 16'd0,     16'd0,    1'b0, 1};
    vecs[6] = '{16'd1000,  16'd33, 16'd30,   16'd10,   1'b0, 31};
    vecs[7] = '{16'd0,     16'd0, 16'hFFFF,  16'd0,    1'b1, 1};
    vecs[8] = '{16'd65535, 16'd1, 16'd65535, 16'd0,    1'b0, 65536};

    // reset then idle
    repeat (2) @(negedge clk);
    chk("reset quot", quot, 0);
    chk("reset rem", rem, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset div_zero", div_zero, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle outputs", {busy, done, div_zero, quot, rem}, 0);
    end

    // table-driven vectors
    for (int i = 0; i < 9; i++) begin
      run_div(vecs[i].a, vecs[i].b, 0, lat);
      check_result($sformatf("vec%0d", i), vecs[i], lat);
    end

    // start pulsed while running is ignored
    v = '{16'd200, 16'd3, 16'd66, 16'd2, 1'b0, 67};
    run_div(v.a, v.b, 5, lat);
    check_result("start_in_run", v, lat);

    // start held high: back-to-back divisions, operands changed mid-run
    @(negedge clk);
    dataa = 16'd20;
    datab = 16'd4;
    start = 1'b1;
    @(negedge clk);
    chk("held busy", busy, 1);
    dataa = 16'd30;
    datab = 16'd7;
    lat = 0;
    while (!done && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    chk("held first latency", lat, 6);
    chk("held first quot", quot, 5);
    chk("held first rem", rem, 0);
    idle_cycles = 0;
    lat = 0;
    @(negedge clk);
    while (!done && lat < LIMIT) begin
      if (!busy) idle_cycles++;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("held idle gap", idle_cycles, 1);
    chk("held second quot", quot, 4);
    chk("held second rem", rem, 2);
    @(negedge clk);
    @(negedge clk);

    // reset mid-run discards the division
    @(negedge clk);
    dataa = 16'd1000;
    datab = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst quot", quot, 0);
    chk("midrst rem", rem, 0);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    chk("midrst no done", seen_done, 0);
    v = '{16'd81, 16'd9, 16'd9, 16'd0, 1'b0, 10};
    run_div(v.a, v.b, 0, lat);
    check_result("after_rst", v, lat);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_div_sub
